// File: rtl/rx_mf_slicer_pkg.sv
// Shared sizing and saturation helpers for the matched-filter receiver and its bench.
package rx_pkg;

  function automatic int full_nbits(input int data_nbits, input int coef_nbits, input int ncoef);
    return data_nbits + coef_nbits + $clog2(ncoef);
  endfunction

  // Arithmetic right shift (truncating toward -inf) then clamp to a signed out_width range.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] value,
                                                   input int unsigned      shift,
                                                   input int unsigned      out_width);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = value >>> shift;
    hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_width - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/rx_mf_slicer_mf_channel.sv
// One channel of the matched filter: valid-gated sample delay line and full-width MAC.
module mf_channel
  import rx_pkg::*;
#(
  parameter int NCOEF      = 24,
  parameter int COEF_NBITS = 8,
  parameter int DATA_NBITS = 8,
  parameter int FULL_NBITS = full_nbits(DATA_NBITS, COEF_NBITS, NCOEF)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_NBITS-1:0]        sample_in,
  input  logic [NCOEF*COEF_NBITS-1:0]  coef_bus,
  output logic signed [FULL_NBITS-1:0] y
);

  logic signed [DATA_NBITS-1:0] dline [NCOEF];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NCOEF; k++) dline[k] <= '0;
    end else if (in_valid) begin
      dline[0] <= sample_in;
      for (int unsigned k = 1; k < NCOEF; k++) dline[k] <= dline[k-1];
    end
  end

  // Tap 0 sits in the MSBs of the coefficient bus.
  always_comb begin
    y = '0;
    for (int unsigned k = 0; k < NCOEF; k++) begin
      y = y + FULL_NBITS'(dline[k]) *
              FULL_NBITS'($signed(coef_bus[(NCOEF-1-k)*COEF_NBITS +: COEF_NBITS]));
    end
  end

endmodule

// File: rtl/rx_mf_slicer.sv
// Multi-channel matched-filter receiver: shared coefficient RAM, symbol-phase decimation,
// hard/soft decisions and a sticky saturation flag.
module rx_mf_slicer
  import rx_pkg::*;
#(
  parameter int                         UPSAMPLE   = 4,
  parameter int                         NCOEF      = 24,
  parameter int                         COEF_NBITS = 8,
  parameter int                         COEF_FBITS = 7,
  parameter int                         DATA_NBITS = 8,
  parameter int                         NCHAN      = 2,
  parameter int                         SOFT_NBITS = 8,
  parameter logic [NCOEF*COEF_NBITS-1:0] COEF      = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [NCHAN*DATA_NBITS-1:0]   rx_in,
  input  logic [$clog2(UPSAMPLE)-1:0]   phase_in,
  input  logic                          coef_we,
  input  logic [$clog2(NCOEF)-1:0]      coef_addr,
  input  logic [COEF_NBITS-1:0]         coef_data,
  input  logic                          sat_clr,
  output logic                          sym_valid,
  output logic [NCHAN-1:0]              rx_hard,
  output logic [NCHAN*SOFT_NBITS-1:0]   rx_soft,
  output logic                          sat_flag
);

  localparam int FULL_NBITS = full_nbits(DATA_NBITS, COEF_NBITS, NCOEF);
  localparam int PH_W       = $clog2(UPSAMPLE);

  logic [COEF_NBITS-1:0]         coef_mem [NCOEF];
  logic [NCOEF*COEF_NBITS-1:0]   coef_bus;
  logic [PH_W-1:0]               ph;
  logic                          decide;
  logic signed [FULL_NBITS-1:0]  y        [NCHAN];
  logic signed [63:0]            shr_v    [NCHAN];
  logic signed [63:0]            sat_v    [NCHAN];
  logic [SOFT_NBITS-1:0]         soft_nx  [NCHAN];
  logic [NCHAN-1:0]              clamp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < NCOEF; k++)
        coef_mem[k] <= COEF[(NCOEF-1-k)*COEF_NBITS +: COEF_NBITS];
    end else if (coef_we && (int'(coef_addr) < NCOEF)) begin
      coef_mem[coef_addr] <= coef_data;
    end
  end

  always_comb begin
    coef_bus = '0;
    for (int unsigned k = 0; k < NCOEF; k++)
      coef_bus[(NCOEF-1-k)*COEF_NBITS +: COEF_NBITS] = coef_mem[k];
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    mf_channel #(
      .NCOEF      (NCOEF),
      .COEF_NBITS (COEF_NBITS),
      .DATA_NBITS (DATA_NBITS),
      .FULL_NBITS (FULL_NBITS)
    ) u_mf_channel (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .sample_in (rx_in[c*DATA_NBITS +: DATA_NBITS]),
      .coef_bus  (coef_bus),
      .y         (y[c])
    );
  end

  // A clamp happened whenever the saturated value differs from the plain shifted value.
  always_comb begin
    clamp = '0;
    for (int unsigned c = 0; c < NCHAN; c++) begin
      shr_v[c]   = 64'(y[c]) >>> COEF_FBITS;
      sat_v[c]   = sat_shift(64'(y[c]), COEF_FBITS, SOFT_NBITS);
      soft_nx[c] = sat_v[c][SOFT_NBITS-1:0];
      clamp[c]   = (sat_v[c] != shr_v[c]);
    end
  end

  assign decide = in_valid && (ph == phase_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph        <= '0;
      sym_valid <= 1'b0;
      rx_hard   <= '0;
      rx_soft   <= '0;
      sat_flag  <= 1'b0;
    end else begin
      sym_valid <= decide;
      if (in_valid) ph <= (ph == PH_W'(UPSAMPLE - 1)) ? '0 : ph + 1'b1;
      if (decide) begin
        for (int unsigned c = 0; c < NCHAN; c++) begin
          rx_hard[c]                          <= ~y[c][FULL_NBITS-1];
          rx_soft[c*SOFT_NBITS +: SOFT_NBITS] <= soft_nx[c];
        end
      end
      if (decide && (|clamp)) sat_flag <= 1'b1;
      else if (sat_clr)       sat_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_mf_slicer.sv
// Directed self-checking bench for rx_mf_slicer (I/Q, 24 taps, 4x upsampling).
module tb_rx_mf_slicer;
  import rx_pkg::*;

  localparam int US = 4;
  localparam int NC = 24;
  localparam int CB = 8;
  localparam int CF = 7;
  localparam int DB = 8;
  localparam int NCH = 2;
  localparam int SB = 8;
  localparam logic [NC*CB-1:0] COEF_INIT = 192'h0102030405060708090a0b0c0d0e0f101112131415161718;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [NCH*DB-1:0] rx_in;
  logic [1:0]        phase_in;
  logic              coef_we;
  logic [4:0]        coef_addr;
  logic [CB-1:0]     coef_data;
  logic              sat_clr;
  logic              sym_valid;
  logic [NCH-1:0]    rx_hard;
  logic [NCH*SB-1:0] rx_soft;
  logic              sat_flag;

  rx_mf_slicer #(
    .UPSAMPLE   (US),
    .NCOEF      (NC),
    .COEF_NBITS (CB),
    .COEF_FBITS (CF),
    .DATA_NBITS (DB),
    .NCHAN      (NCH),
    .SOFT_NBITS (SB),
    .COEF       (COEF_INIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .rx_in     (rx_in),
    .phase_in  (phase_in),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .sat_clr   (sat_clr),
    .sym_valid (sym_valid),
    .rx_hard   (rx_hard),
    .rx_soft   (rx_soft),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  int         cf     [NC];
  int         hist_i [NC];
  int         hist_q [NC];
  int         mph;
  logic [1:0] e_hard;
  int         e_soft_i, e_soft_q;
  logic       e_sat;
  int         cyc = 0;
  bit         rec = 0;
  int         q_soft[$];
  int         q_cyc[$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) begin
      cf[k] = k + 1;
      hist_i[k] = 0;
      hist_q[k] = 0;
    end
    mph = 0;
    e_hard = '0;
    e_soft_i = 0;
    e_soft_q = 0;
    e_sat = 1'b0;
  endtask

  function automatic longint mac(input bit q);
    longint s = 0;
    for (int k = 0; k < NC; k++) s += longint'(q ? hist_q[k] : hist_i[k]) * longint'(cf[k]);
    return s;
  endfunction

  task automatic check_outs(input logic exp_sv);
    chk("sym_valid", sym_valid, exp_sv);
    chk("rx_hard", rx_hard, e_hard);
    chk("rx_soft_i", $signed(rx_soft[SB-1:0]), e_soft_i);
    chk("rx_soft_q", $signed(rx_soft[2*SB-1:SB]), e_soft_q);
    chk("sat_flag", sat_flag, e_sat);
  endtask

  task automatic step(input logic v, input int si, input int sq, input logic clr);
    logic   dec;
    longint yi, yq, si_s, sq_s;
    bit     clamped;
    @(negedge clk);
    in_valid = v;
    rx_in    = {8'(sq), 8'(si)};
    sat_clr  = clr;
    coef_we  = 1'b0;
    dec      = v && (mph == int'(phase_in));
    clamped  = 0;
    if (dec) begin
      yi   = mac(0);
      yq   = mac(1);
      si_s = sat_shift(yi, CF, SB);
      sq_s = sat_shift(yq, CF, SB);
      e_hard   = {yq >= 0, yi >= 0};
      e_soft_i = int'(si_s);
      e_soft_q = int'(sq_s);
      clamped  = ((yi >>> CF) != si_s) || ((yq >>> CF) != sq_s);
    end
    if (dec && clamped) e_sat = 1'b1;
    else if (clr)       e_sat = 1'b0;
    if (v) begin
      for (int k = NC - 1; k > 0; k--) begin
        hist_i[k] = hist_i[k-1];
        hist_q[k] = hist_q[k-1];
      end
      hist_i[0] = int'($signed(8'(si)));
      hist_q[0] = int'($signed(8'(sq)));
      mph = (mph + 1) % US;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outs(dec);
    if (rec && sym_valid) begin
      q_soft.push_back(int'($signed(rx_soft[SB-1:0])));
      q_soft.push_back(int'($signed(rx_soft[2*SB-1:SB])));
      q_cyc.push_back(cyc);
    end
  endtask

  task automatic wr(input int addr, input int data);
    @(negedge clk);
    in_valid  = 1'b0;
    sat_clr   = 1'b0;
    coef_we   = 1'b1;
    coef_addr = 5'(addr);
    coef_data = 8'(data);
    if (addr < NC) cf[addr] = int'($signed(8'(data)));
    @(posedge clk);
    #1;
    cyc++;
    chk("wr_sym_valid", sym_valid, 1'b0);
  endtask

  int sym_i[8] = '{127, -127, -127, 127, 127, -127, 127, -127};
  int sym_q[8] = '{-127, -127, 127, 127, -127, 127, 127, -127};
  int ref_soft[$];
  int n_pulse, first_off, acc_cnt;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; rx_in = '0; phase_in = 2'd0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; sat_clr = 1'b0;
    model_reset();
    #12;
    check_outs(1'b0);
    @(negedge clk);
    rst = 1'b1;

    // impulse response through the ramp coefficients
    for (int n = 0; n < 32; n++) begin
      step(1'b1, (n == 0) ? 64 : 0, (n == 0) ? -64 : 0, 1'b0);
      if (n % 4 == 0) begin
        chk("imp_soft_i", $signed(rx_soft[SB-1:0]), (n >= 4 && n <= 24) ? n / 2 : 0);
        chk("imp_soft_q", $signed(rx_soft[2*SB-1:SB]), (n >= 4 && n <= 24) ? -(n / 2) : 0);
      end
    end

    // single-tap hard decisions
    wr(0, 127);
    for (int k = 1; k < NC; k++) wr(k, 0);
    n_pulse = 0;
    for (int n = 0; n < 33; n++) begin
      step(1'b1, (n < 32) ? sym_i[n/4] : 0, (n < 32) ? sym_q[n/4] : 0, 1'b0);
      if (sym_valid) n_pulse++;
      if (n % 4 == 0 && n >= 4) begin
        chk("hard_i", rx_hard[0], sym_i[n/4-1] > 0);
        chk("hard_q", rx_hard[1], sym_q[n/4-1] > 0);
        chk("hard_soft_i", $signed(rx_soft[SB-1:0]), sym_i[n/4-1] > 0 ? 126 : -127);
      end
    end
    chk("hard_pulses", n_pulse, 9);
    step(1'b1, 0, 0, 1'b0);
    step(1'b1, 0, 0, 1'b0);
    step(1'b1, 0, 0, 1'b0);

    // phase sweep on a live stream
    for (int p = 0; p < US; p++) begin
      phase_in = 2'(p);
      n_pulse = 0;
      first_off = -1;
      for (int n = 0; n < 16; n++) begin
        step(1'b1, sym_i[n/2], sym_q[n/2], 1'b0);
        if (sym_valid) begin
          n_pulse++;
          if (first_off < 0) first_off = n;
        end
      end
      chk("phase_pulses", n_pulse, 4);
      chk("phase_offset", first_off, p);
    end
    phase_in = 2'd0;

    // gap-free reference run, then the same data with in_valid every 3rd cycle
    for (int n = 0; n < 24; n++) step(1'b1, 0, 0, 1'b0);
    rec = 1;
    for (int n = 0; n < 32; n++) step(1'b1, ((n * 53) % 256) - 128, 100 - 7 * n, 1'b0);
    rec = 0;
    ref_soft = q_soft;
    q_soft.delete();
    q_cyc.delete();
    for (int n = 0; n < 24; n++) step(1'b1, 0, 0, 1'b0);
    rec = 1;
    for (int n = 0; n < 32; n++) begin
      step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b0);
      step(1'b1, ((n * 53) % 256) - 128, 100 - 7 * n, 1'b0);
    end
    rec = 0;
    chk("gap_count", q_soft.size(), ref_soft.size());
    for (int i = 0; i < q_soft.size() && i < ref_soft.size(); i++) chk("gap_soft", q_soft[i], ref_soft[i]);
    for (int i = 1; i < q_cyc.size(); i++) chk("gap_spacing", q_cyc[i] - q_cyc[i-1], 12);

    // saturation, sat_clr, set-wins, then all-zero coefficients
    for (int k = 0; k < NC; k++) wr(k, 127);
    for (int n = 0; n < 28; n++) step(1'b1, 127, -127, 1'b0);
    chk("sat_soft_i", $signed(rx_soft[SB-1:0]), 127);
    chk("sat_soft_q", $signed(rx_soft[2*SB-1:SB]), -128);
    chk("sat_set", sat_flag, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    chk("sat_clr", sat_flag, 1'b0);
    step(1'b1, 127, -127, 1'b1);
    chk("sat_set_wins", sat_flag, 1'b1);
    for (int n = 0; n < 3; n++) step(1'b1, 127, -127, 1'b0);
    for (int k = 0; k < NC; k++) wr(k, 0);
    wr(30, 127);
    for (int n = 0; n < 8; n++) begin
      step(1'b1, 127, -127, 1'b0);
      if (n % 4 == 0) chk("zero_coef_soft", $signed(rx_soft[SB-1:0]), 0);
    end

    // mid-stream reset: outputs clear at once, coefficients revert, alignment restarts
    wr(0, 64);
    phase_in = 2'd2;
    for (int n = 0; n < 10; n++) step(1'b1, 50, -30, 1'b0);
    chk("pre_rst_soft", $signed(rx_soft[SB-1:0]), 25);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    #2;
    model_reset();
    check_outs(1'b0);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    acc_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      step(1'b1, 50, -30, 1'b0);
      acc_cnt++;
      if (sym_valid) break;
    end
    chk("rst_first_sym", sym_valid ? acc_cnt : 99, 3);
    for (int n = 0; n < 12; n++) step(1'b1, 50, -30, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
